tcdm_bank_responder: RTL and testbench

- Slave-side endpoint of the TCDM interconnect. One instance per SRAM bank in a tile.
- Accepts tile-local TCDM slave requests: address, payload (meta_id, core_id, amo, data), wen, be, ini_addr.
- Drives a single-port SRAM with 1-cycle read latency and executes plain loads/stores, RISC-V AMOs and LR/SC.
- Returns exactly one TCDM slave response per request, carrying back meta_id, core_id and ini_addr, through a backpressurable response FIFO.

---
 rtl/tcdm_bank_responder.sv | 205 ++++++++++++++++++++
 tb/tb_tcdm_bank_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_bank_responder.sv
// TCDM slave endpoint for one SRAM bank: plain loads/stores, RISC-V AMOs and LR/SC,
// with in-order responses through a fall-through, backpressurable response FIFO.
module tcdm_bank_responder #(
  parameter int unsigned BankAddrWidth = 8,
  parameter int unsigned MetaIdWidth   = 6,
  parameter int unsigned CoreIdWidth   = 2,
  parameter int unsigned IniAddrWidth  = 2,
  parameter int unsigned RespDepth     = 2,
  parameter bit          LrScEnable    = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [BankAddrWidth-1:0] req_addr_i,
  input  logic                     req_wen_i,
  input  logic [3:0]               req_be_i,
  input  logic [31:0]              req_data_i,
  input  logic [3:0]               req_amo_i,
  input  logic [MetaIdWidth-1:0]   req_meta_id_i,
  input  logic [CoreIdWidth-1:0]   req_core_id_i,
  input  logic [IniAddrWidth-1:0]  req_ini_addr_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [31:0]              resp_data_o,
  output logic [MetaIdWidth-1:0]   resp_meta_id_o,
  output logic [CoreIdWidth-1:0]   resp_core_id_o,
  output logic [IniAddrWidth-1:0]  resp_ini_addr_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [BankAddrWidth-1:0] mem_addr_o,
  output logic [3:0]               mem_be_o,
  output logic [31:0]              mem_wdata_o,
  input  logic [31:0]              mem_rdata_i
);

  localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CntW = $clog2(RespDepth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(RespDepth - 1);

  typedef enum logic {IDLE, AMO_WB} state_e;
  typedef enum logic [1:0] {SRC_RDATA, SRC_ZERO, SRC_ONE} src_e;
  typedef enum logic [3:0] {
    AMO_NONE = 4'h0, AMO_SWAP = 4'h1, AMO_ADD = 4'h2, AMO_AND  = 4'h3,
    AMO_OR   = 4'h4, AMO_XOR  = 4'h5, AMO_MAX = 4'h6, AMO_MAXU = 4'h7,
    AMO_MIN  = 4'h8, AMO_MINU = 4'h9, AMO_LR  = 4'hA, AMO_SC   = 4'hB
  } amo_e;

  typedef struct packed {
    logic [31:0]             data;
    logic [MetaIdWidth-1:0]  meta;
    logic [CoreIdWidth-1:0]  core;
    logic [IniAddrWidth-1:0] ini;
  } resp_t;

  state_e                   state;
  logic                     p_valid;
  src_e                     p_src;
  amo_e                     p_amo;
  logic [BankAddrWidth-1:0] p_addr;
  logic [31:0]              p_operand;
  logic [MetaIdWidth-1:0]   p_meta;
  logic [CoreIdWidth-1:0]   p_core;
  logic [IniAddrWidth-1:0]  p_ini;

  logic                     resv_valid;
  logic [BankAddrWidth-1:0] resv_addr;
  logic [CoreIdWidth-1:0]   resv_core;
  logic [IniAddrWidth-1:0]  resv_ini;

  resp_t                    fifo_q [RespDepth];
  logic [PtrW-1:0]          wptr, rptr;
  logic [CntW-1:0]          count;

  amo_e        amo_op;
  logic        is_amo, is_lr, is_sc, is_store, resv_holder, sc_ok;
  logic        accept, push, pop;
  logic [31:0] amo_new;
  resp_t       push_entry, head;

  always_comb begin
    amo_op      = (req_amo_i > 4'hB) ? AMO_NONE : amo_e'(req_amo_i);
    is_amo      = (amo_op >= AMO_SWAP) && (amo_op <= AMO_MINU);
    is_lr       = (amo_op == AMO_LR);
    is_sc       = (amo_op == AMO_SC);
    is_store    = (amo_op == AMO_NONE) && req_wen_i;
    resv_holder = resv_valid && (resv_core == req_core_id_i) && (resv_ini == req_ini_addr_i);
    sc_ok       = LrScEnable && resv_holder && (resv_addr == req_addr_i);
    // Credit check: a request accepted last cycle still owes a FIFO slot.
    req_ready_o = !rst_i && (state == IDLE) && ((32'(count) + 32'(p_valid)) < RespDepth);
    accept      = req_valid_i && req_ready_o;
  end

  always_comb begin
    amo_new = mem_rdata_i;
    unique case (p_amo)
      AMO_SWAP: amo_new = p_operand;
      AMO_ADD:  amo_new = mem_rdata_i + p_operand;
      AMO_AND:  amo_new = mem_rdata_i & p_operand;
      AMO_OR:   amo_new = mem_rdata_i | p_operand;
      AMO_XOR:  amo_new = mem_rdata_i ^ p_operand;
      AMO_MAX:  amo_new = ($signed(p_operand) > $signed(mem_rdata_i)) ? p_operand : mem_rdata_i;
      AMO_MAXU: amo_new = (p_operand > mem_rdata_i) ? p_operand : mem_rdata_i;
      AMO_MIN:  amo_new = ($signed(p_operand) < $signed(mem_rdata_i)) ? p_operand : mem_rdata_i;
      AMO_MINU: amo_new = (p_operand < mem_rdata_i) ? p_operand : mem_rdata_i;
      default:  amo_new = mem_rdata_i;
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (!rst_i) begin
      if (state == AMO_WB) begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = p_addr;
        mem_be_o    = '1;
        mem_wdata_o = amo_new;
      end else if (accept && !(is_sc && !sc_ok)) begin
        mem_req_o   = 1'b1;
        mem_we_o    = is_store || is_sc;
        mem_addr_o  = req_addr_i;
        mem_be_o    = req_be_i;
        mem_wdata_o = req_data_i;
      end
    end
  end

  always_comb begin
    push_entry.data = mem_rdata_i;
    if (p_src == SRC_ZERO) push_entry.data = '0;
    else if (p_src == SRC_ONE) push_entry.data = 32'd1;
    push_entry.meta = p_meta;
    push_entry.core = p_core;
    push_entry.ini  = p_ini;
    push            = p_valid && !rst_i;
    // Empty FIFO falls through so the response is visible in the push cycle.
    head            = (count == '0) ? push_entry : fifo_q[rptr];
    resp_valid_o    = !rst_i && ((count != '0) || p_valid);
    pop             = resp_valid_o && resp_ready_i;
    resp_data_o     = head.data;
    resp_meta_id_o  = head.meta;
    resp_core_id_o  = head.core;
    resp_ini_addr_o = head.ini;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr] <= push_entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      p_valid    <= 1'b0;
      resv_valid <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_addr    <= req_addr_i;
        p_operand <= req_data_i;
        p_amo     <= amo_op;
        p_meta    <= req_meta_id_i;
        p_core    <= req_core_id_i;
        p_ini     <= req_ini_addr_i;
        if (is_sc)         p_src <= sc_ok ? SRC_ZERO : SRC_ONE;
        else if (is_store) p_src <= SRC_ZERO;
        else               p_src <= SRC_RDATA;
      end

      unique case (state)
        IDLE:    if (accept && is_amo) state <= AMO_WB;
        AMO_WB:  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (state == AMO_WB) begin
        if (resv_addr == p_addr) resv_valid <= 1'b0;
      end else if (accept) begin
        if (is_lr && LrScEnable) begin
          resv_valid <= 1'b1;
          resv_addr  <= req_addr_i;
          resv_core  <= req_core_id_i;
          resv_ini   <= req_ini_addr_i;
        end else if (is_sc && resv_holder) begin
          resv_valid <= 1'b0;
        end else if (is_store && (resv_addr == req_addr_i)) begin
          resv_valid <= 1'b0;
        end
      end

      if (push) wptr <= (wptr == LastPtr) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == LastPtr) ? '0 : rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: directed scenarios plus random traffic, checked against
// a transaction-level memory/reservation model and an in-order response scoreboard.
module tb_tcdm_bank_responder;

  logic        clk, rst, sram_init;
  logic        req_valid, req_ready, req_wen;
  logic [7:0]  req_addr;
  logic [3:0]  req_be, req_amo;
  logic [31:0] req_data;
  logic [5:0]  req_meta;
  logic [1:0]  req_core, req_ini;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [5:0]  resp_meta;
  logic [1:0]  resp_core, resp_ini;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  tcdm_bank_responder #(
    .BankAddrWidth(8), .MetaIdWidth(6), .CoreIdWidth(2),
    .IniAddrWidth(2), .RespDepth(2), .LrScEnable(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_wen_i(req_wen), .req_be_i(req_be), .req_data_i(req_data), .req_amo_i(req_amo),
    .req_meta_id_i(req_meta), .req_core_id_i(req_core), .req_ini_addr_i(req_ini),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .resp_meta_id_o(resp_meta), .resp_core_id_o(resp_core), .resp_ini_addr_o(resp_ini),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM with one-cycle read latency
  logic [31:0] sram [256];
  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= '0;
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: memory image, reservation, expected responses in order
  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  meta;
    logic [1:0]  core;
    logic [1:0]  ini;
  } exp_t;

  logic [31:0] ref_mem [256];
  exp_t        exp_q [$];
  logic        rv_valid;
  logic [7:0]  rv_addr;
  logic [1:0]  rv_core, rv_ini;
  logic        undo_v;
  logic [7:0]  undo_addr;
  logic [31:0] undo_old;
  logic        prev_stall;
  logic [31:0] prev_data;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] amo_ref(input logic [3:0] op, input logic [31:0] old, input logic [31:0] x);
    int signed so, sx;
    so = old;
    sx = x;
    case (op)
      4'd1: return x;
      4'd2: return old + x;
      4'd3: return old & x;
      4'd4: return old | x;
      4'd5: return old ^ x;
      4'd6: return (sx > so) ? x : old;
      4'd7: return (x > old) ? x : old;
      4'd8: return (sx < so) ? x : old;
      4'd9: return (x < old) ? x : old;
      default: return old;
    endcase
  endfunction

  task automatic model_accept();
    logic [3:0]  a;
    logic [31:0] r;
    logic        holder;
    a = (req_amo > 4'd11) ? 4'd0 : req_amo;
    r = '0;
    if (a >= 4'd1 && a <= 4'd9) begin
      r = ref_mem[req_addr];
      undo_v = 1'b1;
      undo_addr = req_addr;
      undo_old = r;
      ref_mem[req_addr] = amo_ref(a, r, req_data);
      if (rv_addr == req_addr) rv_valid = 1'b0;
    end else if (a == 4'd10) begin
      r = ref_mem[req_addr];
      rv_valid = 1'b1;
      rv_addr = req_addr;
      rv_core = req_core;
      rv_ini = req_ini;
    end else if (a == 4'd11) begin
      holder = rv_valid && rv_core == req_core && rv_ini == req_ini;
      if (holder && rv_addr == req_addr) begin
        ref_mem[req_addr] = merge(ref_mem[req_addr], req_data, req_be);
        r = 32'd0;
      end else begin
        r = 32'd1;
      end
      if (holder) rv_valid = 1'b0;
    end else if (req_wen) begin
      ref_mem[req_addr] = merge(ref_mem[req_addr], req_data, req_be);
      if (rv_addr == req_addr) rv_valid = 1'b0;
    end else begin
      r = ref_mem[req_addr];
    end
    exp_q.push_back('{data: r, meta: req_meta, core: req_core, ini: req_ini});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sram_init) for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    if (rst) begin
      // An AMO accepted just before reset never writes back.
      if (undo_v) ref_mem[undo_addr] = undo_old;
      undo_v = 1'b0;
      rv_valid = 1'b0;
      prev_stall = 1'b0;
      exp_q.delete();
    end else begin
      undo_v = 1'b0;
      if (prev_stall) begin
        chk("resp_stable_v", 32'(resp_valid), 32'd1);
        chk("resp_stable_d", resp_data, prev_data);
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_meta", 32'(resp_meta), 32'(e.meta));
          chk("resp_core", 32'(resp_core), 32'(e.core));
          chk("resp_ini", 32'(resp_ini), 32'(e.ini));
        end
      end
      if (req_valid && req_ready) model_accept();
      prev_stall = resp_valid && !resp_ready;
      prev_data = resp_data;
    end
  end

  task automatic do_req(input logic [7:0] a, input logic w, input logic [3:0] be, input logic [31:0] d,
                        input logic [3:0] amo, input logic [5:0] m, input logic [1:0] c, input logic [1:0] i);
    logic got;
    @(posedge clk); #1;
    req_addr = a; req_wen = w; req_be = be; req_data = d;
    req_amo = amo; req_meta = m; req_core = c; req_ini = i;
    req_valid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
      else @(posedge clk);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req_accept", 32'(got), 32'd1);
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] d);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk(tag, resp_data, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, drained;
    logic hit;
    rst = 1'b1; sram_init = 1'b1;
    undo_v = 1'b0; rv_valid = 1'b0; prev_stall = 1'b0;
    req_valid = 1'b1; req_addr = '0; req_wen = 1'b0; req_be = '0; req_data = '0;
    req_amo = '0; req_meta = '0; req_core = '0; req_ini = '0; resp_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; sram_init = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Store then load with one-cycle response latency
    do_req(8'd5, 1'b1, 4'hF, 32'hDEADBEEF, 4'd0, 6'h11, 2'd1, 2'd2);
    expect_resp("st_resp", 32'd0);
    do_req(8'd5, 1'b0, 4'hF, 32'd0, 4'd0, 6'h12, 2'd3, 2'd1);
    expect_resp("ld_data", 32'hDEADBEEF);
    chk("ld_meta", 32'(resp_meta), 32'h12);
    chk("ld_core", 32'(resp_core), 32'd3);
    chk("ld_ini", 32'(resp_ini), 32'd1);

    // AMO ADD wraps, then signed MIN
    do_req(8'd3, 1'b1, 4'hF, 32'd7, 4'd0, 6'h20, 2'd0, 2'd0);
    do_req(8'd3, 1'b0, 4'h0, 32'hFFFFFFFA, 4'd2, 6'h21, 2'd0, 2'd0);
    expect_resp("add_old", 32'd7);
    chk("amo_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("amo_ready_back", 32'(req_ready), 32'd1);
    chk("add_mem", sram[3], 32'd1);
    do_req(8'd3, 1'b0, 4'h0, 32'hFFFFFFFE, 4'd8, 6'h22, 2'd0, 2'd0);
    expect_resp("min_old", 32'd1);
    @(negedge clk);
    chk("min_mem", sram[3], 32'hFFFFFFFE);

    // LR/SC success then second SC fails
    do_req(8'd9, 1'b0, 4'hF, 32'd0, 4'hA, 6'h30, 2'd1, 2'd0);
    expect_resp("lr1", 32'd0);
    do_req(8'd9, 1'b0, 4'hF, 32'h12345678, 4'hB, 6'h31, 2'd1, 2'd0);
    expect_resp("sc1_ok", 32'd0);
    chk("sc1_mem", sram[9], 32'h12345678);
    do_req(8'd9, 1'b0, 4'hF, 32'hAAAA5555, 4'hB, 6'h32, 2'd1, 2'd0);
    expect_resp("sc2_fail", 32'd1);
    chk("sc2_mem", sram[9], 32'h12345678);

    // Foreign store breaks the reservation
    do_req(8'd9, 1'b0, 4'hF, 32'd0, 4'hA, 6'h33, 2'd0, 2'd0);
    expect_resp("lr2", 32'h12345678);
    do_req(8'd9, 1'b1, 4'hF, 32'h0BADF00D, 4'd0, 6'h34, 2'd2, 2'd0);
    do_req(8'd9, 1'b0, 4'hF, 32'h11111111, 4'hB, 6'h35, 2'd0, 2'd0);
    expect_resp("sc3_fail", 32'd1);
    chk("sc3_mem", sram[9], 32'h0BADF00D);

    // Backpressure: only RespDepth requests get credit
    do_req(8'd40, 1'b1, 4'hF, 32'hA0, 4'd0, 6'h01, 2'd0, 2'd0);
    do_req(8'd41, 1'b1, 4'hF, 32'hA1, 4'd0, 6'h02, 2'd0, 2'd0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    acc = 0;
    req_addr = 8'd40; req_wen = 1'b0; req_amo = 4'd0; req_meta = 6'h3A; req_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      hit = req_ready;
      @(posedge clk); #1;
      if (hit) begin
        acc++;
        req_addr = 8'(40 + acc);
        req_meta = 6'(6'h3A + acc);
      end
    end
    req_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd2);
    @(negedge clk);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    chk("bp_head", resp_data, 32'hA0);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    drained = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (resp_valid) drained++;
    end
    chk("bp_drained", 32'(drained), 32'd2);
    chk("bp_resume", 32'(req_ready), 32'd1);

    // Reset during AMO writeback
    do_req(8'd20, 1'b1, 4'hF, 32'd5, 4'd0, 6'h05, 2'd0, 2'd0);
    do_req(8'd20, 1'b0, 4'hF, 32'd0, 4'hA, 6'h06, 2'd0, 2'd0);
    do_req(8'd20, 1'b0, 4'hF, 32'd1, 4'd2, 6'h07, 2'd0, 2'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("amo_rst_mem_req", 32'(mem_req), 32'd0);
    chk("amo_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("amo_rst_mem", sram[20], 32'd5);
    do_req(8'd20, 1'b0, 4'hF, 32'd9, 4'hB, 6'h08, 2'd0, 2'd0);
    expect_resp("sc_after_rst", 32'd1);
    chk("sc_after_rst_mem", sram[20], 32'd5);

    // Random traffic
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      hit = req_valid && req_ready;
      @(posedge clk); #1;
      resp_ready = ($urandom_range(0, 9) < 7);
      if (hit || !req_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          req_addr = 8'($urandom_range(0, 15));
          req_wen  = 1'($urandom_range(0, 1));
          req_be   = 4'($urandom_range(0, 15));
          req_data = $urandom;
          case ($urandom_range(0, 4))
            0, 1:    req_amo = 4'd0;
            2:       req_amo = 4'($urandom_range(10, 11));
            default: req_amo = 4'($urandom_range(0, 15));
          endcase
          req_meta = 6'($urandom_range(0, 63));
          req_core = 2'($urandom_range(0, 3));
          req_ini  = 2'($urandom_range(0, 3));
          req_valid = 1'b1;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_resp_valid", 32'(resp_valid), 32'd0);
    for (int i = 0; i < 48; i++) chk($sformatf("mem_%0d", i), sram[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
